// File: rtl/mealy_seq_driver_pkg.sv
// Shared types and defaults for the Mealy sequence-detector driver.
package mealy_seq_driver_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 6;
endpackage

// File: rtl/mealy_seq_driver_shreg.sv
// Load/shift-right word register with serial LSB output and bit-index counter.
module seq_shift_reg #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_lsb,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_last
);
    logic [WIDTH-1:0] r_data;
    logic [IDX_W-1:0] r_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_idx  <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_idx  <= '0;
        end else if (i_shift) begin
            r_data <= r_data >> 1;
            r_idx  <= o_last ? '0 : r_idx + IDX_W'(1);
        end
    end

    assign o_lsb  = r_data[0];
    assign o_idx  = r_idx;
    assign o_last = (r_idx == IDX_W'(WIDTH - 1));
endmodule

// File: rtl/mealy_seq_driver.sv
// Drives a bit-serial Mealy detector with one word, LSB first, and collects its hits.
module mealy_seq_driver
    import mealy_seq_driver_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_seq_in,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_det_rst,
    output logic             o_det_inp,
    input  logic             i_det_outp,
    output logic [CNT_W-1:0] o_hit_count,
    output logic [WIDTH-1:0] o_hit_map,
    output logic [CNT_W-1:0] o_first_hit_idx,
    output logic             o_any_hit
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state, w_next;
    logic             w_accept, w_step, w_lsb, w_last;
    logic [IDX_W-1:0] w_idx;
    logic [CNT_W-1:0] r_hit_count, r_first_idx;
    logic [WIDTH-1:0] r_hit_map;

    assign w_accept = (r_state == ST_IDLE) && i_start && !i_abort;
    // An aborted RUN cycle does not record its sample.
    assign w_step   = (r_state == ST_RUN) && !i_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_CLR;
            ST_CLR:  w_next = i_abort ? ST_IDLE : ST_RUN;
            ST_RUN:  if (i_abort)    w_next = ST_IDLE;
                     else if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    seq_shift_reg #(.WIDTH(WIDTH), .IDX_W(IDX_W)) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_shift(w_step),
        .i_data (i_seq_in),
        .o_lsb  (w_lsb),
        .o_idx  (w_idx),
        .o_last (w_last)
    );

    // hit_map is cleared on accept, so its OR marks whether a hit was already seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count <= '0;
            r_hit_map   <= '0;
            r_first_idx <= '0;
        end else if (w_accept) begin
            r_hit_count <= '0;
            r_hit_map   <= '0;
            r_first_idx <= '0;
        end else if (w_step) begin
            r_hit_map[w_idx] <= i_det_outp;
            if (i_det_outp) begin
                r_hit_count <= r_hit_count + CNT_W'(1);
                if (!(|r_hit_map)) r_first_idx <= CNT_W'(w_idx);
            end
        end
    end

    assign o_busy          = (r_state == ST_CLR) || (r_state == ST_RUN);
    assign o_done          = (r_state == ST_DONE);
    assign o_det_rst       = (r_state != ST_RUN);
    assign o_det_inp       = (r_state == ST_RUN) ? w_lsb : 1'b0;
    assign o_hit_count     = r_hit_count;
    assign o_hit_map       = r_hit_map;
    assign o_first_hit_idx = r_first_idx;
    assign o_any_hit       = |r_hit_map;
endmodule

// File: tb/tb_mealy_seq_driver.sv
// Scoreboard bench for mealy_seq_driver with a stub or a "101" Mealy detector attached.
module tb_mealy_seq_driver;
    localparam int W = 32;
    localparam int C = 6;

    logic         clk = 0, rst = 1, start = 0, abort = 0;
    logic [W-1:0] seq_in = '0;
    logic         busy, done, det_rst, det_inp, det_outp;
    logic [C-1:0] hit_count, first_hit_idx;
    logic [W-1:0] hit_map;
    logic         any_hit;
    logic         use_real = 0;
    logic [1:0]   dst;
    int           cyc = 0, total = 0, bad = 0;

    typedef struct {
        logic [C-1:0] cnt;
        logic [W-1:0] map;
        logic [C-1:0] idx;
        int           acc;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mealy_seq_driver #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_abort(abort), .i_seq_in(seq_in),
        .o_busy(busy), .o_done(done), .o_det_rst(det_rst), .o_det_inp(det_inp),
        .i_det_outp(det_outp), .o_hit_count(hit_count), .o_hit_map(hit_map),
        .o_first_hit_idx(first_hit_idx), .o_any_hit(any_hit)
    );

    // Overlapping "101" detector: 0 = idle, 1 = seen 1, 2 = seen 10.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || det_rst) dst <= 2'd0;
        else case (dst)
            2'd0:    dst <= det_inp ? 2'd1 : 2'd0;
            2'd1:    dst <= det_inp ? 2'd1 : 2'd2;
            default: dst <= det_inp ? 2'd1 : 2'd0;
        endcase
    end
    assign det_outp = use_real ? (dst == 2'd2 && det_inp) : det_inp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Window reference for the "101" detector, independent of any FSM formulation.
    function automatic exp_t ref101(input logic [W-1:0] w);
        exp_t e;
        e.cnt = '0; e.map = '0; e.idx = '0; e.acc = 0;
        for (int k = 2; k < W; k++)
            if (w[k] && !w[k-1] && w[k-2]) begin
                if (e.map == '0) e.idx = C'(k);
                e.map[k] = 1'b1;
                e.cnt = e.cnt + 1'b1;
            end
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            chk("det_inp_quiet", {62'd0, det_rst, det_rst & det_inp}, {62'd0, det_rst, 1'b0});
            if (done) begin
                if (sb.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
                else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("hit_count", 64'(hit_count), 64'(e.cnt));
                    chk("hit_map", 64'(hit_map), 64'(e.map));
                    chk("first_idx", 64'(first_hit_idx), 64'(e.idx));
                    chk("any_hit", 64'(any_hit), 64'(e.map != '0));
                    chk("done_latency", 64'(cyc - e.acc), 64'(W + 1));
                end
            end
        end
    end

    task automatic launch(input logic [W-1:0] w, input exp_t e, input bit push, input bit wait_idle);
        if (wait_idle) begin
            int n = 0;
            do begin @(negedge clk); n++; end while ((busy || done) && n < 200);
            if (n >= 200) chk("idle_timeout", 64'd1, 64'd0);
        end
        @(posedge clk); #1;
        start = 1; seq_in = w;
        @(posedge clk); #1;
        start = 0;
        e.acc = cyc;
        if (push) sb.push_back(e);
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge clk); n++; end while (!done && n < 200);
        if (n >= 200) chk("done_timeout", 64'd1, 64'd0);
    endtask

    function automatic exp_t mk(input int cnt, input logic [W-1:0] map, input int idx);
        exp_t e;
        e.cnt = C'(cnt); e.map = map; e.idx = C'(idx); e.acc = 0;
        return e;
    endfunction

    initial begin
        exp_t e;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_det_rst", 64'(det_rst), 64'd1);
        chk("rst_det_inp", 64'(det_inp), 64'd0);
        chk("rst_count", 64'(hit_count), 64'd0);
        chk("rst_map", 64'(hit_map), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // Test 1 and edge words with the stub detector
        launch(32'b0011_1000_1111_0111_0011_1000_1111_0011,
               mk(19, 32'b0011_1000_1111_0111_0011_1000_1111_0011, 0), 1, 1);
        wait_done();
        launch(32'h0000_0100, mk(1, 32'h0000_0100, 8), 1, 1);
        wait_done();
        launch(32'h0, mk(0, 32'h0, 0), 1, 1);
        wait_done();
        launch(32'hFFFF_FFFF, mk(32, 32'hFFFF_FFFF, 0), 1, 1);
        wait_done();

        // start at k=5 ignored; start in the cycle after done accepted
        launch(32'h0000_00F0, mk(4, 32'h0000_00F0, 4), 1, 1);
        repeat (6) @(posedge clk);
        #1 start = 1; seq_in = 32'hFFFF_FFFF;
        @(posedge clk); #1 start = 0;
        wait_done();
        launch(32'h8000_0000, mk(1, 32'h8000_0000, 31), 1, 0);
        wait_done();

        // abort together with start in IDLE
        @(negedge clk);
        @(posedge clk); #1 start = 1; abort = 1;
        @(posedge clk); #1 start = 0; abort = 0;
        chk("abort_wins_busy", 64'(busy), 64'd0);

        // abort at k=10
        launch(32'hFFFF_FFFF, mk(0, 0, 0), 0, 1);
        repeat (11) @(posedge clk);
        #1 abort = 1;
        @(posedge clk); #1 abort = 0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_det_rst", 64'(det_rst), 64'd1);
        chk("abort_count", 64'(hit_count), 64'd10);
        chk("abort_map", 64'(hit_map), 64'h3FF);
        repeat (40) @(posedge clk);
        chk("abort_hold", 64'(hit_count), 64'd10);

        // rst at k=3
        launch(32'hFFFF_FFFF, mk(0, 0, 0), 0, 1);
        repeat (4) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_det_rst", 64'(det_rst), 64'd1);
        chk("mrst_det_inp", 64'(det_inp), 64'd0);
        chk("mrst_count", 64'(hit_count), 64'd0);
        chk("mrst_map", 64'(hit_map), 64'd0);
        chk("mrst_any", 64'(any_hit), 64'd0);
        @(posedge clk); #1 rst = 0;
        launch(32'h0000_0006, mk(2, 32'h0000_0006, 1), 1, 1);
        wait_done();

        // real "101" detector
        @(negedge clk);
        use_real = 1;
        e = ref101(32'b0011_1000_1111_0111_0011_1000_1111_0011);
        launch(32'b0011_1000_1111_0111_0011_1000_1111_0011, e, 1, 1);
        chk("clr_det_rst", 64'(det_rst), 64'd1);
        chk("clr_busy", 64'(busy), 64'd1);
        @(posedge clk); #1;
        chk("bit0_det_rst", 64'(det_rst), 64'd0);
        wait_done();
        @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
